// File: rtl/ram_responder.sv
// ram_responder: DEPTH x DATA_W synchronous RAM serving the accumulator CPU's
// memory bus. One-cycle registered read, write-through on stores, out-of-range
// flagging, saturating store-transaction counter.
// Optional feature macro: MEM_CLEAR_SWEEP_EN -- after reset, writes INIT_VAL to
// every word (one per clock) before serving the bus; init_busy is high meanwhile.
module ram_responder #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 7,
  parameter int unsigned       DEPTH     = 128,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0,
  parameter                    INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Mem_Address,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] Data_In,
  output logic [DATA_W-1:0] Mem_Data,
  output logic              addr_err,
  output logic [15:0]       wr_cnt,
  output logic              init_busy
);

  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // one extra bit so DEPTH == 2**ADDR_W is representable
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {ST_INIT, ST_SERVE} state_t;

  state_t              state;
  logic                wr_q;
  logic                in_range;
  logic                access;
  logic [IDX_W-1:0]    idx;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_wa;
  logic [DATA_W-1:0]   mem_wd;
  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef MEM_CLEAR_SWEEP_EN
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  logic [IDX_W-1:0] ptr;
`endif

  // address decode: unsigned compare against the implemented depth
  always_comb begin
    in_range = {1'b0, Mem_Address} < DEPTH_L;
    access   = rd | wr;
    idx      = Mem_Address[IDX_W-1:0];
  end

  // single RAM write port: bus stores in SERVE, clear sweep in INIT
  always_comb begin
    mem_we = 1'b0;
    mem_wa = idx;
    mem_wd = Data_In;
    if (state == ST_SERVE) begin
      mem_we = wr & in_range;
    end
`ifdef MEM_CLEAR_SWEEP_EN
    else begin
      mem_we = 1'b1;
      mem_wa = ptr;
      mem_wd = INIT_VAL;
    end
`endif
  end

  // RAM array update (contents intentionally not reset)
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // bus FSM: read/write-through data path, error pulse, store counter, sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Mem_Data <= '0;
      addr_err <= 1'b0;
      wr_cnt   <= '0;
      wr_q     <= 1'b0;
`ifdef MEM_CLEAR_SWEEP_EN
      state    <= ST_INIT;
      ptr      <= '0;
`else
      state    <= ST_SERVE;
`endif
    end else begin
      wr_q     <= wr;
      addr_err <= 1'b0;
      case (state)
        ST_SERVE: begin
          if (wr && !wr_q && (wr_cnt != '1)) wr_cnt <= wr_cnt + 16'd1;
          if (access && !in_range) begin
            Mem_Data <= '0;
            addr_err <= 1'b1;
          end else if (wr) begin
            Mem_Data <= Data_In;
          end else if (rd) begin
            Mem_Data <= mem[idx];
          end
        end
        default: begin
`ifdef MEM_CLEAR_SWEEP_EN
          Mem_Data <= '0;
          if (ptr == LAST) state <= ST_SERVE;
          else             ptr   <= ptr + IDX_W'(1);
`else
          state <= ST_SERVE;
`endif
        end
      endcase
    end
  end

`ifdef MEM_CLEAR_SWEEP_EN
  assign init_busy = (state == ST_INIT);
`else
  assign init_busy = 1'b0;
`endif

endmodule
